// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants, fetch entry type and helpers
package mips_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch stage bundle: imem request/response, redirect, decode handoff
interface instr_fetch_if;
  import mips_pkg::*;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [31:0]        imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [31:0]        if_pc;
  logic [31:0]        if_pc_plus4;
  logic [5:0]         if_opcode;
  logic [5:0]         if_func;

  modport master (
    output imem_req_valid, imem_req_addr,
    output if_valid, if_instr, if_pc, if_pc_plus4, if_opcode, if_func,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  if_valid, if_instr, if_pc, if_pc_plus4, if_opcode, if_func,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, if_ready
  );

endinterface

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - synchronous FIFO with flush; push while full is honoured when a pop happens
module instr_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS fetch stage: PC, credit-limited imem requests, stale-response drop, decode FIFO
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic [CW:0]   credit_used;
  logic          req_valid, req_fire, push, pop, if_valid;
  fetch_entry_t  push_entry, head_entry;

  // Credit counts only registered state so a response always finds FIFO space.
  always_comb begin
    credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    req_valid   = !rst && !bus.redirect_valid && (credit_used < DEPTH_C);
    req_fire    = req_valid && bus.imem_req_ready;
    push        = bus.imem_rsp_valid && !bus.redirect_valid && (drop_q == '0);
    if_valid    = !rst && !bus.redirect_valid && !fifo_empty;
    pop         = if_valid && bus.if_ready;
    push_entry  = '{pc: rsp_pc_q, instr: bus.imem_rsp_data};
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (bus.redirect_valid) begin
      // Everything still unanswered after this cycle belongs to the old path.
      fetch_pc_d    = word_align(bus.redirect_pc);
      rsp_pc_d      = word_align(bus.redirect_pc);
      outstanding_d = outstanding_q - CW'(bus.imem_rsp_valid);
      drop_d        = outstanding_q - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (bus.imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  instr_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.if_valid       = if_valid;
  assign bus.if_instr       = head_entry.instr;
  assign bus.if_pc          = head_entry.pc;
  assign bus.if_pc_plus4    = head_entry.pc + 32'd4;
  assign bus.if_opcode      = head_entry.instr[OPCODE_MSB:OPCODE_LSB];
  assign bus.if_func        = head_entry.instr[FUNC_MSB:FUNC_LSB];

  a_rsp_has_space: assert property (@(posedge clk) disable iff (rst)
    !(bus.imem_rsp_valid && !bus.redirect_valid && (drop_q == '0) && fifo_full));

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized bench for instr_fetch against an in-order memory and program-order model
module tb_instr_fetch;
  import mips_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        memq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          epoch   = 0;
  int          buffered = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] exp_fetch = RPC;
  logic [31:0] exp_del   = RPC;
  logic [31:0] prev_addr = '0;
  bit          prev_stall = 1'b0;
  logic        s_req_valid, s_if_valid;
  logic [31:0] s_req_addr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0C0F_FEE5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs, sample after settling, check, then advance the model.
  task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit rr, input bit ir);
    req_t        h;
    bit          rsp_now, fire, xfer;
    int          lat;
    logic [31:0] w;
    @(negedge clk);
    rst                = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.imem_req_ready = rr;
    bus.if_ready       = ir;
    rsp_now            = !r && (memq.size() > 0) && (memq[0].due <= cyc);
    bus.imem_rsp_valid = rsp_now;
    bus.imem_rsp_data  = rsp_now ? instr_of(memq[0].addr) : $urandom();
    #1;
    s_req_valid = bus.imem_req_valid;
    s_if_valid  = bus.if_valid;
    s_req_addr  = bus.imem_req_addr;
    fire = 1'b0;
    xfer = 1'b0;
    if (r) begin
      check("rst_req_valid", s_req_valid, 0);
      check("rst_if_valid", s_if_valid, 0);
    end else begin
      check("req_valid", s_req_valid, (!rv && (memq.size() + buffered < DEPTH)));
      check("if_valid", s_if_valid, (!rv && buffered > 0));
      if (prev_stall && !rv) check("addr_hold", s_req_addr, prev_addr);
      fire = s_req_valid && rr;
      xfer = s_if_valid && ir;
      if (fire) check("req_addr", s_req_addr, exp_fetch);
      if (xfer) begin
        w = instr_of(exp_del);
        check("if_pc", bus.if_pc, exp_del);
        check("if_instr", bus.if_instr, w);
        check("if_pc_plus4", bus.if_pc_plus4, exp_del + 32'd4);
        check("if_opcode", {26'b0, bus.if_opcode}, w >> 26);
        check("if_func", {26'b0, bus.if_func}, w & 32'h3F);
      end
    end
    if (r) begin
      memq.delete();
      buffered   = 0;
      exp_fetch  = RPC;
      exp_del    = RPC;
      epoch++;
      prev_stall = 1'b0;
      last_due   = 0;
    end else begin
      if (xfer && !rv) begin
        if (buffered > 0) buffered--;
        exp_del += 32'd4;
      end
      if (rsp_now) begin
        h = memq.pop_front();
        if (!rv && h.epoch == epoch) buffered++;
      end
      if (fire && !rv) begin
        lat     = $urandom_range(lat_max, lat_min);
        h.addr  = exp_fetch;
        h.epoch = epoch;
        h.due   = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        last_due = h.due;
        memq.push_back(h);
        exp_fetch += 32'd4;
      end
      if (rv) begin
        buffered  = 0;
        epoch++;
        exp_fetch = {rpc[31:2], 2'b00};
        exp_del   = exp_fetch;
      end
      prev_stall = s_req_valid && !rr && !rv;
      prev_addr  = s_req_addr;
    end
    cyc++;
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_ready       = 1'b0;

    repeat (3) step(1, 0, 0, 1, 1);

    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, 1, 1);
      if (k == 0) begin
        check("first_req_valid", s_req_valid, 1);
        check("first_req_addr", s_req_addr, RPC);
      end
      check("stream_valid", s_if_valid, (k >= 2));
    end

    for (int k = 0; k < 10; k++) step(0, 0, 0, 1, 0);
    check("stall_req_valid", s_req_valid, 0);
    check("stall_if_valid", s_if_valid, 1);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 1, 1);

    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) step(0, 0, 0, 1, 1);

    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 6; k++) step(0, 0, 0, 1, 1);
    step(0, 1, 32'h0000_0100, 1, 1);
    for (int k = 0; k < 12; k++) step(0, 0, 0, 1, 1);
    step(0, 1, 32'h0000_0203, 1, 1);
    step(0, 1, 32'h0000_0203, 1, 1);
    for (int k = 0; k < 12; k++) step(0, 0, 0, 1, 1);

    lat_min = 1; lat_max = 1;
    step(0, 1, 32'hFFFF_FFF8, 1, 1);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 1, 1);

    lat_min = 2; lat_max = 2;
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 1, 1);

    lat_min = 1; lat_max = 4;
    for (int k = 0; k < 3000; k++) begin
      step(($urandom % 500) == 0, ($urandom % 30) == 0, $urandom,
           ($urandom % 4) != 0, ($urandom % 10) < 7);
    end

    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 20; k++) step(0, 0, 0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
